// File: rtl/station_rr_merge_if.sv
// station_rr_merge_if: handshake bundle for the round-robin token merge station.
interface station_rr_merge_if #(
    parameter int PC_WIDTH   = 8,
    parameter int CC_ID_BITS = 2,
    parameter int NUM_IN     = 4
);
    localparam int TW = PC_WIDTH + CC_ID_BITS;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*TW-1:0]     in_data;
    logic [NUM_IN-1:0]        in_ready;
    logic                     out_valid;
    logic [TW-1:0]            out_data;
    logic                     out_ready;
    logic [2**CC_ID_BITS-1:0] present_cc_id;
    logic                     full;
    logic                     running;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, present_cc_id, full, running
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, present_cc_id, full, running
    );
endinterface

// File: rtl/station_rr_merge.sv
// station_rr_merge: NUM_IN-to-1 round-robin token merge through a FIFO with per-CC occupancy.
// Optional STATION_RR_MERGE_STATS_EN adds hwm (count high-water mark) and stall_cnt outputs.
module station_rr_merge #(
    parameter int PC_WIDTH         = 8,
    parameter int CC_ID_BITS       = 2,
    parameter int NUM_IN           = 4,
    parameter int FIFO_COUNT_WIDTH = 3
) (
    input logic clk,
    input logic rst,
    station_rr_merge_if.slave bus
`ifdef STATION_RR_MERGE_STATS_EN
    ,
    output logic [FIFO_COUNT_WIDTH:0] hwm,
    output logic [15:0]               stall_cnt
`endif
);
    localparam int TW    = PC_WIDTH + CC_ID_BITS;
    localparam int DEPTH = 2 ** FIFO_COUNT_WIDTH;
    localparam int IW    = $clog2(NUM_IN);
    localparam int CW    = FIFO_COUNT_WIDTH + 1;
    localparam int NCC   = 2 ** CC_ID_BITS;

    logic [TW-1:0]               mem [DEPTH];
    logic [FIFO_COUNT_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]               count, count_next;
    logic [IW-1:0]               rr, gnt, idx;
    logic                        found, push, pop, valid;
    logic [TW-1:0]               push_data, head;
    logic [CC_ID_BITS-1:0]       push_cc, pop_cc;

    // First valid input after the last granted one wins.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = IW'((int'(rr) + k) % NUM_IN);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign valid      = count != '0 && !rst;
    assign push       = found && count < CW'(DEPTH) && !rst;
    assign pop        = valid && bus.out_ready;
    assign push_data  = bus.in_data[gnt*TW +: TW];
    assign head       = mem[rd_ptr];
    assign push_cc    = push_data[TW-1 -: CC_ID_BITS];
    assign pop_cc     = head[TW-1 -: CC_ID_BITS];
    assign count_next = count + CW'(push) - CW'(pop);

    assign bus.in_ready  = push ? NUM_IN'(1) << gnt : '0;
    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? head : '0;
    assign bus.full      = count == CW'(DEPTH);
    assign bus.running   = |bus.in_valid || valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr     <= IW'(NUM_IN - 1);
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr     <= gnt;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    for (genvar c = 0; c < NCC; c++) begin : g_cc
        logic [CW-1:0] cnt;
        always_ff @(posedge clk) begin
            if (rst) cnt <= '0;
            else cnt <= cnt + CW'(push && push_cc == CC_ID_BITS'(c)) - CW'(pop && pop_cc == CC_ID_BITS'(c));
        end
        assign bus.present_cc_id[c] = cnt != '0;
    end

`ifdef STATION_RR_MERGE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm       <= '0;
            stall_cnt <= '0;
        end else begin
            if (count_next > hwm) hwm <= count_next;
            if (|bus.in_valid && bus.full && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_station_rr_merge.sv
// tb_station_rr_merge: directed stimulus with an expected-token queue checked by a separate output monitor.
module tb_station_rr_merge;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [9:0] exp_q[$];

    station_rr_merge_if #(.PC_WIDTH(8), .CC_ID_BITS(2), .NUM_IN(4)) bus ();
`ifdef STATION_RR_MERGE_STATS_EN
    logic [3:0]  hwm;
    logic [15:0] stall_cnt;
`endif

    station_rr_merge #(.PC_WIDTH(8), .CC_ID_BITS(2), .NUM_IN(4), .FIFO_COUNT_WIDTH(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef STATION_RR_MERGE_STATS_EN
        ,
        .hwm(hwm),
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_in(input int i, input logic [9:0] t);
        bus.in_data[i*10 +: 10] = t;
    endtask

    function automatic logic [9:0] tok(input int i);
        return 10'(i * 256 + 'h30 + i);
    endfunction

    // Monitor: pops the expected queue on every output handshake, checks the CC/count invariant.
    always @(negedge clk) begin
        if (!rst) begin
            int sum;
            sum = int'(dut.g_cc[0].cnt) + int'(dut.g_cc[1].cnt) + int'(dut.g_cc[2].cnt) + int'(dut.g_cc[3].cnt);
            chk("cc_sum_eq_count", 32'(sum), 32'(dut.count));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_data: got %0h expected no token at %0t", bus.out_data, $time);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sample();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_present", 32'(bus.present_cc_id), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_running", 32'(bus.running), 0);
        step();

        bus.in_valid = 4'b0010;
        set_in(1, 10'h21A);
        exp_q.push_back(10'h21A);
        sample();
        chk("single_in_ready", 32'(bus.in_ready), 32'b0010);
        step();
        bus.in_valid = '0;
        sample();
        chk("single_out_valid", 32'(bus.out_valid), 1);
        chk("single_out_data", 32'(bus.out_data), 32'h21A);
        chk("single_present", 32'(bus.present_cc_id), 32'b0100);
        step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        sample();
        chk("single_drained", 32'(bus.out_valid), 0);
        step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_in(i, tok(i));
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(tok(k % 4));
            sample();
            chk("rr_grant", 32'(bus.in_ready), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_count", 32'(dut.count), 1);
            step();
        end
        bus.in_valid = '0;
        step();
        bus.out_ready = 1'b0;
        sample();
        chk("rr_drained", 32'(bus.out_valid), 0);
        step();

        bus.in_valid = 4'b0001;
        for (int j = 0; j < 8; j++) begin
            set_in(0, 10'h040 + 10'(j));
            exp_q.push_back(10'h040 + 10'(j));
            sample();
            chk("fill_in_ready", 32'(bus.in_ready), 32'b0001);
            step();
        end
        set_in(0, 10'h048);
        sample();
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_flag", 32'(bus.full), 1);
        chk("full_present", 32'(bus.present_cc_id), 32'b0001);
        step();
        bus.out_ready = 1'b1;
        sample();
        chk("full_no_bypass", 32'(bus.in_ready), 0);
        step();
        bus.out_ready = 1'b0;
        sample();
        chk("after_pop_count", 32'(dut.count), 7);
        chk("after_pop_in_ready", 32'(bus.in_ready), 32'b0001);
        chk("after_pop_full", 32'(bus.full), 0);
`ifdef STATION_RR_MERGE_STATS_EN
        chk("stats_hwm", 32'(hwm), 8);
        chk("stats_stall", 32'(stall_cnt), 2);
`endif
        exp_q.push_back(10'h048);
        step();
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        repeat (8) step();
        bus.out_ready = 1'b0;
        sample();
        chk("fill_drained", 32'(bus.out_valid), 0);
        chk("fill_queue_empty", 32'(exp_q.size()), 0);
        step();

        bus.in_valid = 4'b0010;
        begin
            logic [9:0] seq [3];
            seq = '{10'h050, 10'h051, 10'h352};
            for (int j = 0; j < 3; j++) begin
                set_in(1, seq[j]);
                exp_q.push_back(seq[j]);
                sample();
                chk("cc_fill_in_ready", 32'(bus.in_ready), 32'b0010);
                step();
            end
        end
        set_in(1, 10'h053);
        exp_q.push_back(10'h053);
        bus.out_ready = 1'b1;
        sample();
        chk("cc_swap_in_ready", 32'(bus.in_ready), 32'b0010);
        step();
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        sample();
        chk("cc0_count", 32'(dut.g_cc[0].cnt), 2);
        chk("cc_swap_present", 32'(bus.present_cc_id), 32'b1001);
        chk("cc_swap_count", 32'(dut.count), 3);
        step();
        bus.out_ready = 1'b1;
        step();
        sample();
        chk("cc_pop1_present", 32'(bus.present_cc_id), 32'b1001);
        step();
        sample();
        chk("cc_pop2_present", 32'(bus.present_cc_id), 32'b0001);
        step();
        bus.out_ready = 1'b0;
        sample();
        chk("cc_empty_valid", 32'(bus.out_valid), 0);
        chk("cc_empty_present", 32'(bus.present_cc_id), 0);
        step();

        bus.in_valid = 4'b0100;
        for (int j = 0; j < 5; j++) begin
            set_in(2, 10'h160 + 10'(j));
            exp_q.push_back(10'h160 + 10'(j));
            step();
        end
        sample();
        chk("pre_rst_count", 32'(dut.count), 5);
        step();
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_in(i, tok(i));
        rst = 1'b1;
        exp_q.delete();
        sample();
        chk("in_rst_in_ready", 32'(bus.in_ready), 0);
        step();
        rst = 1'b0;
        sample();
        chk("post_rst_valid", 32'(bus.out_valid), 0);
        chk("post_rst_present", 32'(bus.present_cc_id), 0);
        chk("post_rst_count", 32'(dut.count), 0);
        chk("post_rst_grant", 32'(bus.in_ready), 32'b0001);
`ifdef STATION_RR_MERGE_STATS_EN
        chk("post_rst_hwm", 32'(hwm), 0);
        chk("post_rst_stall", 32'(stall_cnt), 0);
`endif
        exp_q.push_back(tok(0));
        step();
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        sample();
        chk("final_valid", 32'(bus.out_valid), 0);
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
